counter_updown_mod: RTL and testbench
=====================================

// Module: counter_updown_mod
// PURPOSE
//  Parametrised modulo-(limit+1) up/down counter with enable, synchronous
//  load, wrap/saturate mode and cascade outputs. Generalises the 4-bit
//  limit counter for timers, clock dividers, BCD digit chains and
//  multi-digit displays on DE0-CV designs.
//  Counters chain by feeding one stage's tc into the next stage's en.
// PARAMETERS
//  WIDTH     8   counter, limit and load_val width in bits (>=2)
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  en        in   1      count enable / cascade carry-in
//  up        in   1      1 = count up, 0 = count down
//  mode      in   1      0 = wrap, 1 = saturate
//  load      in   1      synchronous load of load_val
//  load_val  in   WIDTH  value to load
//  limit     in   WIDTH  terminal value; count range 0..limit
//  count     out  WIDTH  registered count
//  co        out  1      registered one-cycle wrap pulse (carry up / borrow down)
//  tc        out  1      comb. terminal count: en & at_term, for cascading
//  sat       out  1      registered: 1 while held at a saturated terminal
// BEHAVIOUR
//  - All state updates on the rising edge of clk. Priority: rst > load > en.
//  - Reset values: count=0, co=0, sat=0. rst mid-count gives count=0 on the
//    next edge, and any pending co is dropped.
//  - at_term = up ? (count >= limit) : (count == 0). Use unsigned compares.
//  - load=1: count<=load_val, co<=0, sat<=0. load_val>limit is accepted as-is
//    and is not clipped.
//  - en=0 and load=0: count holds, co<=0, sat holds.
//  - en=1, up=1:
//    - count<limit: count+1.
//    - count>=limit, mode=0: count<=0, co<=1.
//    - count>=limit, mode=1: count<=limit, sat<=1, co<=0.
//  - en=1, up=0:
//    - count>limit: count<=limit, co<=0. This brings it back into range.
//    - 0<count<=limit: count-1.
//    - count==0, mode=0: count<=limit, co<=1.
//    - count==0, mode=1: count holds at 0, sat<=1, co<=0.
//  - sat clears on the first enabled step away from the terminal, i.e. after
//    a direction change or a mode change to 0.
//  - limit=0 with mode=0: count stays 0 and co=1 every enabled cycle.
//  - co latency: asserted the cycle after the wrapping edge, exactly 1 cycle
//    wide per wrap.
//  - tc is combinational with zero latency, for a same-cycle enable in the
//    next stage. It is never asserted while en=0.
//  - No arithmetic overflow: the +1 path is only taken when count<limit,
//    which is <=2^WIDTH-1.
//  - limit may change at any time. It takes effect on the next edge under the
//    rules above.
// TESTING
//  - Up/wrap, WIDTH=8, limit=9, en=1, up=1, mode=0: count 0..9,0.
//    co=1 exactly 1 cycle after 9->0. tc=1 while count=9.
//  - Down/wrap, limit=5, up=0, from reset: count goes 0->5 with co=1, then
//    4,3,2,1,0,5.
//  - Saturate up, mode=1, limit=3: count 0,1,2,3,3,3. sat=1 from the 3->3
//    hold, co never asserted. Set up=0: count 2, sat=0.
//  - Load, and load vs en: load=1, load_val=200, limit=100, en=1 gives
//    count=200. Next up step: count=0, co=1. Repeat with up=0: next count=100.
//  - Cascade two instances, limit=9 each, stage-1 en=tc0: 00..99 decimal.
//    Stage-1 co pulses once per 100 clocks.
//  - rst at count=7 with co pending and en=1: next edge count=0, co=0, sat=0.
//    limit=0: co=1 every cycle.

Source files
------------

// File: rtl/counter_updown_mod.sv
// -----------------------------------------------------------------------------
// counter_updown_mod
//
// Purpose:
//   Parametrised modulo-(limit+1) up/down counter with count enable,
//   synchronous load, wrap/saturate mode and cascade outputs. Stages chain
//   by feeding one stage's tc into the next stage's en, which makes the
//   block usable for timers, clock dividers and BCD digit chains.
//
// Parameters:
//   WIDTH     counter, limit and load_val width in bits (>= 2)
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous, active-high reset
//   en        in   1      count enable / cascade carry-in
//   up        in   1      1 = count up, 0 = count down
//   mode      in   1      0 = wrap, 1 = saturate
//   load      in   1      synchronous load of load_val (beats en)
//   load_val  in   WIDTH  value to load (not clipped to limit)
//   limit     in   WIDTH  terminal value; count range 0..limit
//   count     out  WIDTH  registered count
//   co        out  1      registered one-cycle wrap pulse (carry/borrow)
//   tc        out  1      combinational en & at_term, for cascading
//   sat       out  1      registered, high while held at a saturated terminal
// -----------------------------------------------------------------------------
module counter_updown_mod #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             co,
    output logic             tc,
    output logic             sat
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_co;
    logic             r_sat;

    logic             w_at_term;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_co_nxt;
    logic             w_sat_nxt;

    // Terminal detection: counting up, any value at or above limit is terminal
    // so an out-of-range loaded value wraps/saturates on the next step.
    always_comb begin
        w_at_term = 1'b0;
        if (up) begin
            w_at_term = (r_count >= limit);
        end else begin
            w_at_term = (r_count == ZERO);
        end
    end

    // Next-state selection; load beats en, and co is a pulse so it defaults low.
    always_comb begin
        w_count_nxt = r_count;
        w_co_nxt    = 1'b0;
        w_sat_nxt   = r_sat;
        if (load) begin
            w_count_nxt = load_val;
            w_sat_nxt   = 1'b0;
        end else if (en) begin
            if (up) begin
                if (r_count < limit) begin
                    // +1 only when below limit, so it can never overflow.
                    w_count_nxt = r_count + ONE;
                    w_sat_nxt   = 1'b0;
                end else if (!mode) begin
                    w_count_nxt = ZERO;
                    w_co_nxt    = 1'b1;
                    w_sat_nxt   = 1'b0;
                end else begin
                    w_count_nxt = limit;
                    w_sat_nxt   = 1'b1;
                end
            end else begin
                if (r_count > limit) begin
                    // Out-of-range value counting down snaps back to limit.
                    w_count_nxt = limit;
                    w_sat_nxt   = 1'b0;
                end else if (r_count != ZERO) begin
                    w_count_nxt = r_count - ONE;
                    w_sat_nxt   = 1'b0;
                end else if (!mode) begin
                    w_count_nxt = limit;
                    w_co_nxt    = 1'b1;
                    w_sat_nxt   = 1'b0;
                end else begin
                    w_count_nxt = ZERO;
                    w_sat_nxt   = 1'b1;
                end
            end
        end else begin
            w_count_nxt = r_count;
            w_sat_nxt   = r_sat;
        end
    end

    // State registers with synchronous reset; reset also drops a pending co.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= ZERO;
            r_co    <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_co    <= w_co_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    assign count = r_count;
    assign co    = r_co;
    assign sat   = r_sat;
    // Zero-latency carry-out so the next stage is enabled in the same cycle.
    assign tc    = en & w_at_term;

endmodule

// File: tb/tb_counter_updown_mod.sv
// -----------------------------------------------------------------------------
// tb_counter_updown_mod
//   Directed scenarios plus randomized stimulus against an arithmetic
//   reference model of the counter. A two-stage decimal cascade is built
//   from two extra instances.
// -----------------------------------------------------------------------------
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       mode;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] limit;
    logic [7:0] count;
    logic       co;
    logic       tc;
    logic       sat;

    // cascade signals
    logic       c_en0;
    logic [7:0] c_count0, c_count1;
    logic       c_co0, c_co1, c_tc0, c_tc1, c_sat0, c_sat1;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int   m_count;
    logic m_co;
    logic m_sat;

    always #5 clk = ~clk;

    counter_updown_mod #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .load(load),
        .load_val(load_val), .limit(limit),
        .count(count), .co(co), .tc(tc), .sat(sat)
    );

    counter_updown_mod #(.WIDTH(8)) u_s0 (
        .clk(clk), .rst(rst), .en(c_en0), .up(1'b1), .mode(1'b0), .load(1'b0),
        .load_val(8'd0), .limit(8'd9),
        .count(c_count0), .co(c_co0), .tc(c_tc0), .sat(c_sat0)
    );

    counter_updown_mod #(.WIDTH(8)) u_s1 (
        .clk(clk), .rst(rst), .en(c_tc0), .up(1'b1), .mode(1'b0), .load(1'b0),
        .load_val(8'd0), .limit(8'd9),
        .count(c_count1), .co(c_co1), .tc(c_tc1), .sat(c_sat1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Behavioural reference: modulo arithmetic over the range 0..limit.
    function automatic void model_step();
        int lim  = int'(limit);
        int span = lim + 1;
        if (rst) begin
            m_count = 0; m_co = 1'b0; m_sat = 1'b0;
        end else if (load) begin
            m_count = int'(load_val); m_co = 1'b0; m_sat = 1'b0;
        end else if (!en) begin
            m_co = 1'b0;
        end else if (m_count > lim) begin
            if (!up) begin
                m_count = lim; m_co = 1'b0; m_sat = 1'b0;
            end else if (mode) begin
                m_count = lim; m_co = 1'b0; m_sat = 1'b1;
            end else begin
                m_count = 0; m_co = 1'b1; m_sat = 1'b0;
            end
        end else if (mode && ((up && m_count == lim) || (!up && m_count == 0))) begin
            m_co = 1'b0; m_sat = 1'b1;
        end else begin
            m_co    = up ? (m_count == lim) : (m_count == 0);
            m_count = up ? (m_count + 1) % span : (m_count + span - 1) % span;
            m_sat   = 1'b0;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up = 1'b1; mode = 1'b0; load = 1'b0;
        load_val = 8'd0; limit = 8'd9; c_en0 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (count !== 8'd0 || co !== 1'b0 || sat !== 1'b0 || tc !== 1'b0)
            $display("FAIL reset: count=%0d co=%b sat=%b tc=%b, want 0 0 0 0", count, co, sat, tc);
        else n_pass++;
    endtask

    task automatic test_up_wrap();
        do_reset();
        limit = 8'd9; mode = 1'b0; up = 1'b1; en = 1'b1; load = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            #1;
            n_checks++;
            if (tc !== (((k - 1) % 10) == 9))
                $display("FAIL up_wrap_tc k=%0d: tc=%b want %b", k, tc, (((k - 1) % 10) == 9));
            else n_pass++;
            tick();
            n_checks++;
            if (int'(count) !== k % 10 || co !== (k == 10))
                $display("FAIL up_wrap k=%0d: count=%0d co=%b, want %0d %b", k, count, co, k % 10, (k == 10));
            else n_pass++;
        end
    endtask

    task automatic test_down_wrap();
        int exp_d[7] = '{5, 4, 3, 2, 1, 0, 5};
        do_reset();
        limit = 8'd5; mode = 1'b0; up = 1'b0; en = 1'b1; load = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++;
            if (int'(count) !== exp_d[k-1] || co !== (k == 1 || k == 7))
                $display("FAIL down_wrap k=%0d: count=%0d co=%b, want %0d %b", k, count, co, exp_d[k-1], (k == 1 || k == 7));
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        do_reset();
        limit = 8'd3; mode = 1'b1; up = 1'b1; en = 1'b1; load = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (int'(count) !== ((k < 3) ? k : 3) || sat !== (k >= 4) || co !== 1'b0)
                $display("FAIL saturate k=%0d: count=%0d sat=%b co=%b, want %0d %b 0", k, count, sat, co, ((k < 3) ? k : 3), (k >= 4));
            else n_pass++;
        end
        up = 1'b0;
        tick();
        n_checks++;
        if (count !== 8'd2 || sat !== 1'b0)
            $display("FAIL saturate_release: count=%0d sat=%b, want 2 0", count, sat);
        else n_pass++;
    endtask

    task automatic test_load();
        do_reset();
        limit = 8'd100; load_val = 8'd200; mode = 1'b0; up = 1'b1; en = 1'b1; load = 1'b1;
        tick();
        n_checks++;
        if (count !== 8'd200 || co !== 1'b0)
            $display("FAIL load_up: count=%0d co=%b, want 200 0", count, co);
        else n_pass++;
        load = 1'b0;
        tick();
        n_checks++;
        if (count !== 8'd0 || co !== 1'b1)
            $display("FAIL load_up_step: count=%0d co=%b, want 0 1", count, co);
        else n_pass++;
        load = 1'b1; up = 1'b0;
        tick();
        load = 1'b0;
        tick();
        n_checks++;
        if (count !== 8'd100 || co !== 1'b0)
            $display("FAIL load_down_step: count=%0d co=%b, want 100 0", count, co);
        else n_pass++;
    endtask

    task automatic test_rst_mid();
        do_reset();
        limit = 8'd7; mode = 1'b1; up = 1'b1; en = 1'b1; load = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if (count !== 8'd7 || sat !== 1'b1)
            $display("FAIL pre_rst: count=%0d sat=%b, want 7 1", count, sat);
        else n_pass++;
        mode = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (count !== 8'd0 || co !== 1'b0 || sat !== 1'b0)
            $display("FAIL rst_mid: count=%0d co=%b sat=%b, want 0 0 0", count, co, sat);
        else n_pass++;
    endtask

    task automatic test_limit0();
        do_reset();
        limit = 8'd0; mode = 1'b0; up = 1'b1; en = 1'b1; load = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 4) up = 1'b0;
            #1;
            n_checks++;
            if (tc !== 1'b1)
                $display("FAIL limit0_tc k=%0d: tc=%b want 1", k, tc);
            else n_pass++;
            tick();
            n_checks++;
            if (count !== 8'd0 || co !== 1'b1)
                $display("FAIL limit0 k=%0d: count=%0d co=%b, want 0 1", k, count, co);
            else n_pass++;
        end
    endtask

    task automatic test_cascade();
        int pulses = 0;
        en = 1'b0;
        do_reset();
        c_en0 = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            #1;
            n_checks++;
            if (c_tc1 !== (((k - 1) % 100) == 99))
                $display("FAIL cascade_tc k=%0d: tc1=%b want %b", k, c_tc1, (((k - 1) % 100) == 99));
            else n_pass++;
            tick();
            if (c_co1 === 1'b1) pulses++;
            n_checks++;
            if (int'(c_count1) * 10 + int'(c_count0) !== k % 100 || c_co1 !== ((k % 100) == 0))
                $display("FAIL cascade k=%0d: value=%0d%0d co1=%b, want %0d %b", k, c_count1, c_count0, c_co1, k % 100, ((k % 100) == 0));
            else n_pass++;
        end
        c_en0 = 1'b0;
        n_checks++;
        if (pulses !== 2)
            $display("FAIL cascade_pulses: got %0d want 2", pulses);
        else n_pass++;
    endtask

    task automatic test_random();
        logic exp_tc;
        do_reset();
        m_count = 0; m_co = 1'b0; m_sat = 1'b0;
        limit = 8'd6;
        for (int i = 0; i < 500; i++) begin
            rst      = ($urandom % 60) == 0;
            load     = ($urandom % 10) == 0;
            en       = ($urandom % 4) != 0;
            up       = 1'($urandom % 2);
            mode     = 1'($urandom % 2);
            load_val = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            if ($urandom % 16 == 0)
                limit = ($urandom % 8 == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
            #1;
            exp_tc = en && (up ? (m_count >= int'(limit)) : (m_count == 0));
            n_checks++;
            if (tc !== exp_tc)
                $display("FAIL random_tc i=%0d: tc=%b want %b", i, tc, exp_tc);
            else n_pass++;
            tick();
            model_step();
            n_checks++;
            if (int'(count) !== m_count || co !== m_co || sat !== m_sat)
                $display("FAIL random i=%0d: count=%0d co=%b sat=%b, want %0d %b %b", i, count, co, sat, m_count, m_co, m_sat);
            else n_pass++;
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_load();
        test_rst_mid();
        test_limit0();
        test_cascade();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
